// File: rtl/box_overlay_multi_if.sv
// Pixel stream handshake bundle: valid/ready flow control, start-of-frame flag and pixel data.
//   valid  producer -> consumer  pixel present
//   ready  consumer -> producer  pixel accepted when valid & ready
//   sof    producer -> consumer  pixel is (0,0) of a frame
//   data   producer -> consumer  pixel value, PIX_W bits
`timescale 1ns/1ps
interface box_overlay_multi_if #(
  parameter int unsigned PIX_W = 24
) ();
  logic             valid;
  logic             ready;
  logic             sof;
  logic [PIX_W-1:0] data;

  modport master (output valid, output sof, output data, input ready);
  modport slave  (input valid, input sof, input data, output ready);
endinterface

// File: rtl/box_overlay_multi.sv
// Streaming raster overlay: draws up to NUM_BOXES rectangular outlines (THICK pixels wide,
// drawn inward) onto a pixel stream. Box coordinates are double-buffered: cfg writes land in a
// shadow set, and a commit copies shadow->active on the next (0,0) transfer, so a box never
// tears mid-frame.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cfg_we/cfg_idx        write shadow entry cfg_idx (out-of-range index ignored)
//   cfg_en/x/y/w/h/color  box enable, centre, size, border colour
//   cfg_commit            request shadow->active copy at next frame start
//   in_if  (slave)        input pixel stream
//   out_if (master)       output pixel stream, one register stage
//   frame_done            pulse when last pixel of a frame is accepted
//   sync_err              pulse when in_sof arrives away from (0,0)
`timescale 1ns/1ps
module box_overlay_multi #(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540,
  parameter int unsigned NUM_BOXES  = 4,
  parameter int unsigned THICK      = 2,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned PIX_W      = 24,
  localparam int unsigned IW        = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [IW-1:0]       cfg_idx,
  input  logic                cfg_en,
  input  logic [COORD_W-1:0]  cfg_x,
  input  logic [COORD_W-1:0]  cfg_y,
  input  logic [COORD_W-1:0]  cfg_w,
  input  logic [COORD_W-1:0]  cfg_h,
  input  logic [PIX_W-1:0]    cfg_color,
  input  logic                cfg_commit,
  box_overlay_multi_if.slave  in_if,
  box_overlay_multi_if.master out_if,
  output logic                frame_done,
  output logic                sync_err
);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W+1:0] wide_t;
  typedef logic [PIX_W-1:0]   pix_t;
  typedef enum logic [0:0] {StWaitSof, StStream} state_e;

  localparam coord_t XMax = coord_t'(IMG_WIDTH - 1);
  localparam coord_t YMax = coord_t'(IMG_HEIGHT - 1);
  localparam wide_t  Th   = wide_t'(THICK);

  state_e state_q;
  coord_t x_q, y_q;
  logic   pend_q;
  logic   out_valid_q, out_sof_q;
  pix_t   out_data_q;

  logic   sh_en_q  [NUM_BOXES];
  coord_t sh_x_q   [NUM_BOXES];
  coord_t sh_y_q   [NUM_BOXES];
  coord_t sh_w_q   [NUM_BOXES];
  coord_t sh_h_q   [NUM_BOXES];
  pix_t   sh_col_q [NUM_BOXES];

  // Active set holds precomputed clamped edges, not centre/size.
  logic   act_on_q [NUM_BOXES];
  coord_t act_l_q  [NUM_BOXES];
  coord_t act_r_q  [NUM_BOXES];
  coord_t act_t_q  [NUM_BOXES];
  coord_t act_b_q  [NUM_BOXES];
  pix_t   act_col_q[NUM_BOXES];

  logic   wr_sel [NUM_BOXES];
  logic   eff_en [NUM_BOXES];
  pix_t   eff_col[NUM_BOXES];
  wide_t  lw[NUM_BOXES], rw[NUM_BOXES], tw[NUM_BOXES], bw[NUM_BOXES];
  logic   new_on [NUM_BOXES];

  logic   sel_on [NUM_BOXES];
  wide_t  sel_l[NUM_BOXES], sel_r[NUM_BOXES], sel_t[NUM_BOXES], sel_b[NUM_BOXES];
  pix_t   sel_col[NUM_BOXES];
  logic   hit    [NUM_BOXES];

  logic   in_ready, xfer, counted, origin, resync, last, copy, found;
  coord_t pos_x, pos_y, nxt_x, nxt_y;
  pix_t   pix_d;

  assign in_ready     = ~out_valid_q | out_if.ready;
  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid_q;
  assign out_if.sof   = out_sof_q;
  assign out_if.data  = out_data_q;

  // Edges from the shadow set as it will look after this cycle's write, so a write and a
  // commit issued together are both part of the copy.
  always_comb begin
    for (int i = 0; i < NUM_BOXES; i++) begin
      wr_sel[i]  = cfg_we && (cfg_idx == IW'(i));
      eff_en[i]  = wr_sel[i] ? cfg_en    : sh_en_q[i];
      eff_col[i] = wr_sel[i] ? cfg_color : sh_col_q[i];
      lw[i] = wide_t'(wr_sel[i] ? cfg_x : sh_x_q[i]);
      rw[i] = lw[i];
      tw[i] = wide_t'(wr_sel[i] ? cfg_y : sh_y_q[i]);
      bw[i] = tw[i];
      lw[i] = (lw[i] >= wide_t'((wr_sel[i] ? cfg_w : sh_w_q[i]) >> 1)) ?
              lw[i] - wide_t'((wr_sel[i] ? cfg_w : sh_w_q[i]) >> 1) : '0;
      rw[i] = rw[i] + wide_t'((wr_sel[i] ? cfg_w : sh_w_q[i]) >> 1);
      tw[i] = (tw[i] >= wide_t'((wr_sel[i] ? cfg_h : sh_h_q[i]) >> 1)) ?
              tw[i] - wide_t'((wr_sel[i] ? cfg_h : sh_h_q[i]) >> 1) : '0;
      bw[i] = bw[i] + wide_t'((wr_sel[i] ? cfg_h : sh_h_q[i]) >> 1);
      if (rw[i] > wide_t'(XMax)) rw[i] = wide_t'(XMax);
      if (bw[i] > wide_t'(YMax)) bw[i] = wide_t'(YMax);
      // Fully off-screen boxes collapse to disabled here.
      new_on[i] = eff_en[i] && (lw[i] <= rw[i]) && (tw[i] <= bw[i]);
    end
  end

  // Pixel position: an in_sof always restarts at (0,0), in or out of sync.
  always_comb begin
    xfer    = in_if.valid && in_ready;
    counted = (state_q == StStream) || in_if.sof;
    pos_x   = (state_q == StStream && !in_if.sof) ? x_q : '0;
    pos_y   = (state_q == StStream && !in_if.sof) ? y_q : '0;
    origin  = (pos_x == '0) && (pos_y == '0);
    resync  = (state_q == StStream) && in_if.sof && ((x_q != '0) || (y_q != '0));
    last    = (pos_x == XMax) && (pos_y == YMax);
    copy    = counted && origin && (pend_q || cfg_commit);
    if (pos_x == XMax) begin
      nxt_x = '0;
      nxt_y = (pos_y == YMax) ? '0 : pos_y + coord_t'(1);
    end else begin
      nxt_x = pos_x + coord_t'(1);
      nxt_y = pos_y;
    end
  end

  // Hit test; a freshly committed set already applies to the (0,0) pixel that triggers it.
  always_comb begin
    pix_d = in_if.data;
    found = 1'b0;
    for (int i = 0; i < NUM_BOXES; i++) begin
      sel_on[i]  = copy ? new_on[i]  : act_on_q[i];
      sel_l[i]   = copy ? lw[i]      : wide_t'(act_l_q[i]);
      sel_r[i]   = copy ? rw[i]      : wide_t'(act_r_q[i]);
      sel_t[i]   = copy ? tw[i]      : wide_t'(act_t_q[i]);
      sel_b[i]   = copy ? bw[i]      : wide_t'(act_b_q[i]);
      sel_col[i] = copy ? eff_col[i] : act_col_q[i];
      // Border tests add THICK on the pixel side to avoid underflow of R-THICK / B-THICK.
      hit[i] = sel_on[i] &&
               (wide_t'(pos_x) >= sel_l[i]) && (wide_t'(pos_x) <= sel_r[i]) &&
               (wide_t'(pos_y) >= sel_t[i]) && (wide_t'(pos_y) <= sel_b[i]) &&
               ((wide_t'(pos_x) < sel_l[i] + Th) || (wide_t'(pos_x) + Th > sel_r[i]) ||
                (wide_t'(pos_y) < sel_t[i] + Th) || (wide_t'(pos_y) + Th > sel_b[i]));
      if (counted && hit[i] && !found) begin
        pix_d = sel_col[i];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StWaitSof;
      x_q         <= '0;
      y_q         <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
      for (int i = 0; i < NUM_BOXES; i++) begin
        sh_en_q[i]   <= 1'b0;
        sh_x_q[i]    <= '0;
        sh_y_q[i]    <= '0;
        sh_w_q[i]    <= '0;
        sh_h_q[i]    <= '0;
        sh_col_q[i]  <= '0;
        act_on_q[i]  <= 1'b0;
        act_l_q[i]   <= '0;
        act_r_q[i]   <= '0;
        act_t_q[i]   <= '0;
        act_b_q[i]   <= '0;
        act_col_q[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      for (int i = 0; i < NUM_BOXES; i++) begin
        if (wr_sel[i]) begin
          sh_en_q[i]  <= cfg_en;
          sh_x_q[i]   <= cfg_x;
          sh_y_q[i]   <= cfg_y;
          sh_w_q[i]   <= cfg_w;
          sh_h_q[i]   <= cfg_h;
          sh_col_q[i] <= cfg_color;
        end
      end
      if (xfer && copy) begin
        pend_q <= 1'b0;
        for (int i = 0; i < NUM_BOXES; i++) begin
          act_on_q[i]  <= new_on[i];
          act_l_q[i]   <= coord_t'(lw[i]);
          act_r_q[i]   <= coord_t'(rw[i]);
          act_t_q[i]   <= coord_t'(tw[i]);
          act_b_q[i]   <= coord_t'(bw[i]);
          act_col_q[i] <= eff_col[i];
        end
      end else if (cfg_commit) begin
        pend_q <= 1'b1;
      end
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pix_d;
        out_sof_q   <= counted && origin;
        if (counted) begin
          state_q    <= StStream;
          x_q        <= nxt_x;
          y_q        <= nxt_y;
          frame_done <= last;
          sync_err   <= resync;
        end
      end else if (out_if.ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_box_overlay_multi.sv
// Bench for box_overlay_multi on a reduced 64x48 raster with THICK=2. A behavioural model
// predicts every output pixel into a scoreboard queue; a table of hand-derived spot pixels
// checks the captured frames; hand sequences cover mid-frame commit, resync and reset.
`timescale 1ns/1ps
module tb_box_overlay_multi;
  localparam int W  = 64;
  localparam int H  = 48;
  localparam int NB = 4;
  localparam int TH = 2;
  localparam int CW = 10;
  localparam int PW = 24;
  localparam int IW = 2;
  localparam logic [PW-1:0] RED = 24'hFF0000, GRN = 24'h00FF00, BLU = 24'h0000FF;
  localparam logic [PW-1:0] YEL = 24'hFFFF00, C3 = 24'h123456;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_we = 1'b0, cfg_en = 1'b0, cfg_commit = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [CW-1:0] cfg_x = '0, cfg_y = '0, cfg_w = '0, cfg_h = '0;
  logic [PW-1:0] cfg_color = '0;
  logic          frame_done, sync_err;

  box_overlay_multi_if #(.PIX_W(PW)) in_if ();
  box_overlay_multi_if #(.PIX_W(PW)) out_if ();

  box_overlay_multi #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_BOXES(NB), .THICK(TH), .COORD_W(CW), .PIX_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_color(cfg_color),
    .cfg_commit(cfg_commit), .in_if(in_if), .out_if(out_if),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  typedef struct { logic sof; logic [PW-1:0] data; } exp_t;
  typedef struct { int tid; int px; int py; bit bg; logic [PW-1:0] col; } spot_t;
  exp_t  sb[$];
  spot_t spots[$];

  int tests = 0, fails = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never
  int dut_fd = 0, dut_se = 0, exp_fd = 0, exp_se = 0;
  logic [PW-1:0] cap [W*H];
  int opos = W*H;

  // Reference model state
  int m_sh_en[NB], m_sh_x[NB], m_sh_y[NB], m_sh_w[NB], m_sh_h[NB];
  int m_a_en[NB], m_a_x[NB], m_a_y[NB], m_a_w[NB], m_a_h[NB];
  logic [PW-1:0] m_sh_col[NB], m_a_col[NB];
  bit m_pend = 0, m_stream = 0;
  int mx = 0, my = 0;

  function automatic logic [PW-1:0] pat(int x, int y);
    return {8'(x * 3), 8'(y * 5), 8'hA5};
  endfunction

  function automatic logic [PW-1:0] model_pix(int px, int py, logic [PW-1:0] din);
    for (int i = 0; i < NB; i++) begin
      int l, r, t, b;
      if (m_a_en[i] == 0) continue;
      l = m_a_x[i] - m_a_w[i] / 2; if (l < 0) l = 0;
      r = m_a_x[i] + m_a_w[i] / 2; if (r > W - 1) r = W - 1;
      t = m_a_y[i] - m_a_h[i] / 2; if (t < 0) t = 0;
      b = m_a_y[i] + m_a_h[i] / 2; if (b > H - 1) b = H - 1;
      if (l > r || t > b) continue;
      if (px < l || px > r || py < t || py > b) continue;
      if (px < l + TH || px > r - TH || py < t + TH || py > b - TH) return m_a_col[i];
    end
    return din;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_sh_en[i] = 0; m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_w[i] = 0; m_sh_h[i] = 0;
      m_a_en[i] = 0; m_a_x[i] = 0; m_a_y[i] = 0; m_a_w[i] = 0; m_a_h[i] = 0;
      m_sh_col[i] = '0; m_a_col[i] = '0;
    end
    m_pend = 0; m_stream = 0; mx = 0; my = 0;
  endtask

  task automatic model_accept(input logic s, input logic [PW-1:0] d);
    exp_t e;
    if (!m_stream && !s) begin
      e.sof = 1'b0; e.data = d;
    end else begin
      if (s) begin
        if (m_stream && (mx != 0 || my != 0)) exp_se++;
        mx = 0; my = 0; m_stream = 1;
      end
      if (mx == 0 && my == 0 && m_pend) begin
        m_a_en = m_sh_en; m_a_x = m_sh_x; m_a_y = m_sh_y; m_a_w = m_sh_w; m_a_h = m_sh_h;
        m_a_col = m_sh_col; m_pend = 0;
      end
      e.sof  = (mx == 0 && my == 0);
      e.data = model_pix(mx, my, d);
      if (mx == W - 1 && my == H - 1) exp_fd++;
      mx++;
      if (mx == W) begin mx = 0; my++; if (my == H) my = 0; end
    end
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // One clock: entered at a falling edge, drives inputs, samples just after, exits at next
  // falling edge.
  task automatic cycle(input logic v, input logic s, input logic [PW-1:0] d, output logic acc);
    exp_t e;
    in_if.valid = v; in_if.sof = s; in_if.data = d;
    case (ready_mode)
      0:       out_if.ready = 1'b1;
      1:       out_if.ready = ($urandom_range(0, 1) == 1);
      default: out_if.ready = 1'b0;
    endcase
    #1;
    acc = v && in_if.ready;
    if (frame_done) dut_fd++;
    if (sync_err) dut_se++;
    if (out_if.valid && out_if.ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got %h, required no output", out_if.data);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_if.data), 32'(e.data));
        check("out_sof", 32'(out_if.sof), 32'(e.sof));
      end
      if (out_if.sof) opos = 0;
      if (opos < W*H) begin cap[opos] = out_if.data; opos++; end
    end
    if (acc) model_accept(s, d);
    @(negedge clk);
  endtask

  task automatic push(input logic s, input logic [PW-1:0] d);
    logic acc;
    int tries = 0;
    do begin
      cycle(1'b1, s, d, acc);
      tries++;
      if (tries > 2000) begin
        $display("FAIL push_timeout: in_ready stuck low, required acceptance");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
      end
    end while (!acc);
  endtask

  task automatic idle();
    logic acc;
    cycle(1'b0, 1'b0, '0, acc);
  endtask

  task automatic cfg_box(input int idx, input int en, input int x, input int y, input int w,
                         input int h, input logic [PW-1:0] col, input bit commit);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_en = (en != 0);
    cfg_x = CW'(x); cfg_y = CW'(y); cfg_w = CW'(w); cfg_h = CW'(h);
    cfg_color = col; cfg_commit = commit;
    m_sh_en[idx] = en; m_sh_x[idx] = x; m_sh_y[idx] = y; m_sh_w[idx] = w; m_sh_h[idx] = h;
    m_sh_col[idx] = col;
    if (commit) m_pend = 1;
    idle();
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  // inj: pixel index carrying a stray in_sof; cfg_at: pixel index before which box1 is
  // rewritten to yellow and committed in the same cycle.
  task automatic send_frame(input int inj, input int cfg_at);
    for (int p = 0; p < W*H; p++) begin
      if (p == cfg_at) cfg_box(1, 1, 40, 25, 20, 10, YEL, 1'b1);
      push((p == 0) || (p == inj), pat(p % W, p / W));
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && sb.size() > 0; k++) idle();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_spots(input int tid);
    logic [PW-1:0] want;
    foreach (spots[k]) begin
      if (spots[k].tid != tid) continue;
      want = spots[k].bg ? pat(spots[k].px, spots[k].py) : spots[k].col;
      check($sformatf("spot_t%0d_(%0d,%0d)", tid, spots[k].px, spots[k].py),
            32'(cap[spots[k].py * W + spots[k].px]), 32'(want));
    end
  endtask

  function automatic void add(input int t, input int x, input int y, input bit bg,
                              input logic [PW-1:0] c);
    spots.push_back('{t, x, y, bg, c});
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    // Box0 (30,20) 20x10 -> L20 R40 T15 B25, border rows 15,16,24,25, cols 20,21,39,40
    add(1, 20, 15, 0, RED); add(1, 30, 15, 0, RED); add(1, 40, 25, 0, RED);
    add(1, 30, 16, 0, RED); add(1, 39, 18, 0, RED); add(1, 21, 20, 0, RED);
    add(1, 30, 17, 1, '0);  add(1, 22, 20, 1, '0);  add(1, 30, 20, 1, '0);
    add(1, 41, 20, 1, '0);  add(1, 19, 20, 1, '0);  add(1, 30, 26, 1, '0);
    // Clamped boxes: box0 L=T=0 R=B=25; box1 L55 R63 T40 B47; box3 2x2 renders solid
    add(2, 0, 0, 0, GRN);   add(2, 1, 10, 0, GRN);  add(2, 2, 10, 1, '0);
    add(2, 25, 3, 0, GRN);  add(2, 26, 3, 1, '0);   add(2, 10, 24, 0, GRN);
    add(2, 10, 23, 1, '0);  add(2, 63, 0, 1, '0);   add(2, 63, 10, 1, '0);
    add(2, 63, 44, 0, BLU); add(2, 60, 47, 0, BLU); add(2, 60, 44, 1, '0);
    add(2, 55, 44, 0, BLU); add(2, 40, 30, 0, C3);  add(2, 39, 29, 0, C3);
    // Overlap: box1 (40,25) 20x10 -> L30 R50 T20 B30
    add(3, 30, 24, 0, RED); add(3, 40, 25, 0, RED); add(3, 50, 25, 0, BLU);
    add(3, 30, 30, 0, BLU);
    add(4, 30, 24, 0, BLU); add(4, 40, 25, 1, '0);  add(4, 20, 15, 1, '0);
    // Mid-frame recolour: old colour for whole frame, new colour from next frame
    add(5, 40, 30, 0, BLU); add(5, 30, 21, 0, BLU);
    add(6, 40, 30, 0, YEL); add(6, 30, 21, 0, YEL);
    // After reset: box0 (2,2) 4x4 -> L0 R4 T0 B4
    add(7, 0, 0, 0, RED);   add(7, 4, 4, 0, RED);   add(7, 2, 2, 1, '0);
    add(7, 5, 0, 1, '0);

    model_reset();
    in_if.valid = 1'b0; in_if.sof = 1'b0; in_if.data = '0; out_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_if.valid), 32'd0);
    check("reset_out_sof", 32'(out_if.sof), 32'd0);
    check("reset_out_data", 32'(out_if.data), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_sync_err", 32'(sync_err), 32'd0);
    check("reset_in_ready", 32'(in_if.ready), 32'd1);
    reset = 1'b0;
    idle();

    // Single box
    cfg_box(0, 1, 30, 20, 20, 10, RED, 1'b1);
    send_frame(-1, -1);
    drain();
    check_spots(1);
    check("frame_done_count_1", 32'(dut_fd), 32'd1);

    // Edge clamping, off-screen box, narrow box
    cfg_box(0, 1, 5, 5, 40, 40, GRN, 1'b0);
    cfg_box(1, 1, 60, 45, 10, 10, BLU, 1'b0);
    cfg_box(2, 1, 600, 10, 4, 4, 24'hFFFFFF, 1'b0);
    cfg_box(3, 1, 40, 30, 2, 2, C3, 1'b1);
    send_frame(-1, -1);
    drain();
    check_spots(2);

    // Overlap priority, then disable box0
    cfg_box(0, 1, 30, 20, 20, 10, RED, 1'b0);
    cfg_box(1, 1, 40, 25, 20, 10, BLU, 1'b0);
    cfg_box(2, 0, 0, 0, 0, 0, '0, 1'b0);
    cfg_box(3, 0, 0, 0, 0, 0, '0, 1'b1);
    send_frame(-1, -1);
    drain();
    check_spots(3);
    cfg_box(0, 0, 30, 20, 20, 10, RED, 1'b1);
    send_frame(-1, -1);
    drain();
    check_spots(4);

    // Write + commit in the same cycle, halfway through a frame
    send_frame(-1, W*H/2);
    drain();
    check_spots(5);
    send_frame(-1, -1);
    drain();
    check_spots(6);
    check("frame_done_count_6", 32'(dut_fd), 32'd6);
    check("sync_err_count_0", 32'(dut_se), 32'd0);

    // Random backpressure with a stray sof at (37,2); next frame's sof also resyncs
    ready_mode = 1;
    send_frame(2*W + 37, -1);
    send_frame(-1, -1);
    drain();
    ready_mode = 0;
    check("sync_err_count_2", 32'(dut_se), 32'd2);
    check("frame_done_count_7", 32'(dut_fd), 32'd7);
    check("sync_err_model", 32'(dut_se), 32'(exp_se));
    check("frame_done_model", 32'(dut_fd), 32'(exp_fd));

    // Reset in mid-frame while a stalled pixel is held on the output
    push(1'b1, pat(0, 0));
    for (int i = 1; i < 10; i++) push(1'b0, pat(i, 0));
    ready_mode = 2;
    idle();
    check("stall_out_valid", 32'(out_if.valid), 32'd1);
    check("stall_out_data", 32'(out_if.data), 32'(pat(9, 0)));
    reset = 1'b1;
    #1;
    check("midreset_out_valid", 32'(out_if.valid), 32'd0);
    check("midreset_in_ready", 32'(in_if.ready), 32'd1);
    sb.delete();
    model_reset();
    opos = W*H;
    @(negedge clk);
    reset = 1'b0;
    ready_mode = 0;
    // Box covering the origin: untagged pixels must still pass unmodified
    cfg_box(0, 1, 2, 2, 4, 4, RED, 1'b1);
    for (int i = 0; i < 40; i++) push(1'b0, pat(i, 1));
    drain();
    send_frame(-1, -1);
    drain();
    check_spots(7);
    check("sync_err_final", 32'(dut_se), 32'(exp_se));
    check("frame_done_final", 32'(dut_fd), 32'(exp_fd));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
